// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: FSM states and word width.
package fetch_ctrl_pkg;

    localparam int INST_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return s != IDLE;
    endfunction

endpackage : fetch_ctrl_pkg

// File: rtl/pc_cmd.sv
// Command encoding shared with the PC block: hold, increment or load.
package pc_cmd;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        LOAD = 2'd2
    } cmd;

endpackage : pc_cmd

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and instruction output handshakes.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [WIDTH:0]    imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;

    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [WIDTH:0]    inst_pc;

    // Fetch controller side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    // Memory and downstream consumer side.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, redirect-aware,
// drives the external PC block through cmd/load_pc.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           halt,
    input  logic [WIDTH:0] pc,
    output pc_cmd::cmd     cmd,
    output logic [WIDTH:0] load_pc,
    input  logic           redirect_valid,
    input  logic [WIDTH:0] redirect_pc,
    output logic           busy,
    fetch_ctrl_if.master   bus
);

    state_t            state;
    state_t            next_state;
    logic [WIDTH:0]    req_pc;
    logic              inst_valid_q;
    logic [INST_W-1:0] inst_data_q;
    logic [WIDTH:0]    inst_pc_q;

    logic accept;
    logic capture_req;
    logic capture_resp;
    logic clear_inst;

    assign accept = (state == REQ) && bus.imem_req_ready;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state   = state;
        cmd          = pc_cmd::NONE;
        load_pc      = '0;
        capture_req  = 1'b0;
        capture_resp = 1'b0;
        clear_inst   = 1'b0;

        if (!rst) begin
            next_state = IDLE;
            cmd        = pc_cmd::LOAD;
            load_pc    = RESET_PC;
        end else begin
            if (redirect_valid) begin
                cmd     = pc_cmd::LOAD;
                load_pc = redirect_pc;
            end

            case (state)
                IDLE: begin
                    if (start && !redirect_valid) next_state = REQ;
                end

                REQ: begin
                    if (accept) begin
                        capture_req = 1'b1;
                        if (redirect_valid) begin
                            next_state = FLUSH;
                        end else begin
                            cmd        = pc_cmd::INC;
                            next_state = WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        next_state = bus.imem_resp_valid ? REQ : FLUSH;
                    end else if (bus.imem_resp_valid) begin
                        capture_resp = 1'b1;
                        next_state   = HOLD;
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        clear_inst = 1'b1;
                        next_state = REQ;
                    end else if (bus.inst_ready) begin
                        clear_inst = 1'b1;
                        next_state = halt ? IDLE : REQ;
                    end
                end

                FLUSH: begin
                    // The stale response retires the request even under a new
                    // redirect; waiting for another one would never end.
                    if (bus.imem_resp_valid) next_state = halt ? IDLE : REQ;
                end

                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            req_pc       <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state <= next_state;
            if (capture_req) req_pc <= pc;
            if (capture_resp) begin
                inst_valid_q <= 1'b1;
                inst_data_q  <= bus.imem_resp_data;
                inst_pc_q    <= req_pc;
            end else if (clear_inst) begin
                inst_valid_q <= 1'b0;
            end
        end
    end

    // Request address tracks the PC block directly, so a redirect load shows up one cycle later.
    assign bus.imem_req_valid = rst && (state == REQ);
    assign bus.imem_req_addr  = pc;

    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;

    assign busy = rst && is_busy(state);

endmodule : fetch_ctrl

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 32; PC/address ports are WIDTH+1 bits, [WIDTH:0].
- RESET_PC, default 0; PC value loaded during reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-low reset.
- start, in, 1: begin fetching from the current PC when idle.
- halt, in, 1: stop after the current instruction retires.
- pc, in, WIDTH+1: current PC value from the PC block.
- cmd, out, pc_cmd::cmd: command to the PC block (NONE/INC/LOAD).
- load_pc, out, WIDTH+1: PC load value, meaningful when cmd==LOAD.
- imem_req_valid, in/out pair with imem_req_ready: imem_req_valid out 1, imem_req_ready in 1; instruction-memory request handshake.
- imem_req_addr, out, WIDTH+1: request address.
- imem_resp_valid, in, 1: memory response strobe, single cycle.
- imem_resp_data, in, 32: instruction word.
- redirect_valid, in, 1: branch/jump redirect strobe.
- redirect_pc, in, WIDTH+1: redirect target.
- inst_valid, out, 1: instruction output valid.
- inst_ready, in, 1: downstream accepts the instruction.
- inst_data, out, 32: fetched instruction.
- inst_pc, out, WIDTH+1: address of inst_data.
- busy, out, 1: high when state != IDLE.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, HOLD, FLUSH.
REQ-004 Default outputs each cycle SHALL be: cmd=NONE, load_pc=0, imem_req_valid=0.
REQ-005 IDLE SHALL behave as follows:
- start=1 -> REQ.
- Otherwise remain in IDLE.
- imem_resp_valid is ignored.
REQ-006 REQ SHALL behave as follows:
- imem_req_valid=1 and imem_req_addr=pc, combinationally.
- On imem_req_valid&&imem_req_ready: cmd=INC, capture pc into req_pc, -> WAIT.
REQ-007 At most one memory request SHALL be outstanding at any time.
REQ-008 WAIT SHALL behave as follows:
- On imem_resp_valid: register inst_data=imem_resp_data and inst_pc=req_pc, set inst_valid=1, -> HOLD.
- Latency: response edge to inst_valid high is 1 cycle.
REQ-009 HOLD SHALL behave as follows:
- inst_valid, inst_data and inst_pc are held stable until inst_ready=1.
- On inst_ready: inst_valid=0 next cycle, then -> IDLE if halt=1, else -> REQ.
REQ-010 Redirect SHALL override every other cmd source. In any state with redirect_valid=1, the same cycle drives cmd=LOAD and load_pc=redirect_pc, with these transitions:
- IDLE: stay IDLE.
- REQ, not accepted this cycle: stay REQ.
- REQ, accepted this cycle: -> FLUSH.
- WAIT, no imem_resp_valid: -> FLUSH.
- WAIT with imem_resp_valid in the same cycle: response discarded, -> REQ.
- HOLD: inst_valid=0 next cycle, held instruction discarded even if inst_ready=1 this cycle, -> REQ.
- FLUSH: stay FLUSH.
REQ-011 FLUSH SHALL discard the next imem_resp_valid (inst_valid stays 0), then -> IDLE if halt=1, else -> REQ.
REQ-012 imem_req_addr MAY change while imem_req_valid=1 only in the cycle after a redirect; it is otherwise stable until accepted.
REQ-013 PC increment wrap-around (all-ones to 0) SHALL be left to the PC block; fetch_ctrl imposes no address limit.
REQ-014 imem_resp_valid outside WAIT/FLUSH SHALL be ignored.
REQ-015 halt SHALL be sampled only at HOLD retirement and FLUSH completion; it does not abort a request already issued.

Reset
REQ-016 While rst=0, fetch_ctrl SHALL drive:
- state=IDLE, inst_valid=0, inst_data=0, inst_pc=0, req_pc=0, busy=0, imem_req_valid=0.
- cmd=LOAD, load_pc=RESET_PC, so the PC holds RESET_PC at the first edge after rst rises.
REQ-017 Reset asserted mid-fetch SHALL abandon the outstanding request; a late response after reset release is ignored, since the FSM is in IDLE.
REQ-018 Reset SHALL take priority over redirect_valid and start.

Structure
REQ-019 The FSM state enum SHALL live in shared package fetch_ctrl_pkg; fetch_ctrl SHALL reuse the existing pc_cmd::cmd type unchanged.
REQ-020 fetch_ctrl SHALL NOT instantiate the PC block; the parent connects cmd/load_pc/pc. No sub-module is required.
REQ-021 The design SHALL use one always_ff block for state/output registers and one always_comb block for next-state and cmd.

Verification
REQ-022 A bench SHALL cover these directed scenarios (RESET_PC='h100):
- Reset release: after one start, with memory ready and 1-cycle response: imem_req_addr='h100, then 'h101; inst_pc sequence 'h100, 'h101; cmd=INC exactly once per accepted request.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_data/inst_pc stable, no new request issued, cmd=NONE throughout.
- Redirect in WAIT to 'h200: cmd=LOAD with load_pc='h200 that cycle; the stale response is dropped (inst_valid stays 0); the next request addr is 'h200.
- Redirect with imem_resp_valid in the same WAIT cycle: the response is discarded, no FLUSH entered, the next request addr equals redirect_pc.
- halt=1 during HOLD with inst_ready=1 -> IDLE, busy=0, no further imem_req_valid until start.
- rst=0 asserted in WAIT: cmd=LOAD with 'h100, inst_valid=0; a response arriving after release is ignored.
